// File: rtl/data_cache.sv
// data_cache: direct-mapped write-through no-write-allocate cache with a fixed-latency memory port
module data_cache #(
    parameter int INDEX_BITS  = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        cpuRead,
    input  logic        cpuWrite,
    input  logic [31:0] cpuAddr,
    input  logic [31:0] cpuDataIn,
    output logic [31:0] cpuDataOut,
    output logic        cpuStall,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
);
    localparam int NL = 1 << INDEX_BITS;
    localparam int TW = 30 - INDEX_BITS;
    localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);
    typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [31:0] addr_q, data_q;
    logic [NL-1:0] valid;
    logic [TW-1:0] tags [NL];
    logic [31:0] lines [NL];
    logic [INDEX_BITS-1:0] idx, lidx;
    logic [TW-1:0] tag, ltag;
    logic hit, lhit, last, idle, in_r, in_w, rd_hit, rd_miss, wr_start;
    assign idx      = cpuAddr[INDEX_BITS+1:2];
    assign tag      = cpuAddr[31:INDEX_BITS+2];
    assign lidx     = addr_q[INDEX_BITS+1:2];
    assign ltag     = addr_q[31:INDEX_BITS+2];
    assign hit      = valid[idx] && tags[idx] == tag;
    assign lhit     = valid[lidx] && tags[lidx] == ltag;
    assign last     = cnt == '0;
    // RES gates the combinational outputs so strobes drop the instant reset asserts
    assign idle     = state == IDLE && !RES;
    assign in_r     = state == RMISS && !RES;
    assign in_w     = state == WRITE && !RES;
    assign wr_start = idle && cpuWrite;
    assign rd_hit   = idle && cpuRead && !cpuWrite && hit;
    assign rd_miss  = idle && cpuRead && !cpuWrite && !hit;
    assign cpuStall   = rd_miss || wr_start || ((in_r || in_w) && !last);
    assign memRead    = rd_miss || in_r;
    assign memWrite   = wr_start || in_w;
    assign memAddr    = (rd_miss || wr_start) ? (cpuAddr & ~32'd3) : (in_r || in_w) ? addr_q : 32'd0;
    assign memDataIn  = wr_start ? cpuDataIn : in_w ? data_q : 32'd0;
    assign cpuDataOut = rd_hit ? lines[idx] : (in_r && last) ? memDataOut : 32'd0;
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            valid     <= '0;
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpuWrite) begin
                        state  <= WRITE;
                        cnt    <= CNT_INIT;
                        addr_q <= cpuAddr & ~32'd3;
                        data_q <= cpuDataIn;
                    end else if (cpuRead && hit) begin
                        hitCount <= hitCount + {31'd0, ~&hitCount};
                    end else if (cpuRead) begin
                        state  <= RMISS;
                        cnt    <= CNT_INIT;
                        addr_q <= cpuAddr & ~32'd3;
                    end
                end
                RMISS: begin
                    if (!last) cnt <= cnt - 1'b1;
                    else begin
                        state       <= IDLE;
                        valid[lidx] <= 1'b1;
                        missCount   <= missCount + {31'd0, ~&missCount};
                    end
                end
                WRITE: begin
                    if (!last) cnt <= cnt - 1'b1;
                    else state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Tag/data arrays need no reset; the valid bits guard them
    always_ff @(posedge CLK) begin
        if (state == RMISS && last) begin
            tags[lidx]  <= ltag;
            lines[lidx] <= memDataOut;
        end else if (state == WRITE && last && lhit) begin
            lines[lidx] <= data_q;
        end
    end
endmodule
